// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_ctrl_pkg
// Description : Opcode, state and control-field encodings shared by the
//               multi-cycle MIPS controller blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IEXEC    = 4'd9,
        S_IWB      = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [2:0] c_ALUOP_ADD   = 3'b000;
    localparam logic [2:0] c_ALUOP_SUB   = 3'b001;
    localparam logic [2:0] c_ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] c_ALUOP_AND   = 3'b011;
    localparam logic [2:0] c_ALUOP_OR    = 3'b100;
    localparam logic [2:0] c_ALUOP_SLT   = 3'b101;

    localparam logic [1:0] c_ALUSRCB_B     = 2'b00;
    localparam logic [1:0] c_ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] c_ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] c_REGDST_RT  = 2'b00;
    localparam logic [1:0] c_REGDST_RD  = 2'b01;
    localparam logic [1:0] c_REGDST_R31 = 2'b10;

    localparam logic [1:0] c_MEMTOREG_ALU  = 2'b00;
    localparam logic [1:0] c_MEMTOREG_DATA = 2'b01;
    localparam logic [1:0] c_MEMTOREG_PC   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/maindec_mc_ext.sv
`default_nettype none
// ============================================================================
// Module      : maindec_mc_ext
// Description : Multi-cycle MIPS main decoder FSM with extended ISA, memory
//               ready handshake and illegal-opcode trap.
// Revision    : 1.0 - initial release
// ============================================================================
module maindec_mc_ext
    import mips_ctrl_pkg::*;
#(
    parameter bit EXT_ISA         = 1'b1,
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       branch,
    output logic       branch_ne,
    output logic       iord,
    output logic       immsrc,
    output logic [1:0] memtoreg,
    output logic [1:0] regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state_q;
    state_t state_d;

    logic w_mem_rdy;
    logic w_is_rtype, w_is_lw, w_is_sw, w_is_beq, w_is_bne;
    logic w_is_addi, w_is_andi, w_is_ori, w_is_slti, w_is_j, w_is_jal;
    logic w_is_branch, w_is_imm;

    // Extended opcodes decode to nothing when the extension is disabled,
    // so they fall through to the illegal-opcode path.
    assign w_is_rtype  = (op == c_OP_RTYPE);
    assign w_is_lw     = (op == c_OP_LW);
    assign w_is_sw     = (op == c_OP_SW);
    assign w_is_beq    = (op == c_OP_BEQ);
    assign w_is_addi   = (op == c_OP_ADDI);
    assign w_is_j      = (op == c_OP_J);
    assign w_is_bne    = EXT_ISA && (op == c_OP_BNE);
    assign w_is_andi   = EXT_ISA && (op == c_OP_ANDI);
    assign w_is_ori    = EXT_ISA && (op == c_OP_ORI);
    assign w_is_slti   = EXT_ISA && (op == c_OP_SLTI);
    assign w_is_jal    = EXT_ISA && (op == c_OP_JAL);
    assign w_is_branch = w_is_beq || w_is_bne;
    assign w_is_imm    = w_is_addi || w_is_andi || w_is_ori || w_is_slti;

    assign w_mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (w_mem_rdy) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_rtype) begin
                    state_d = S_EXECUTE;
                end else if (w_is_lw || w_is_sw) begin
                    state_d = S_MEMADR;
                end else if (w_is_branch) begin
                    state_d = S_BRANCH;
                end else if (w_is_imm) begin
                    state_d = S_IEXEC;
                end else if (w_is_j) begin
                    state_d = S_JUMP;
                end else if (w_is_jal) begin
                    state_d = S_JAL;
                end else begin
                    state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                end
            end
            S_MEMADR: begin
                if (w_is_lw) begin
                    state_d = S_MEMREAD;
                end else if (w_is_sw) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD: begin
                if (w_mem_rdy) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWRITE: begin
                if (w_mem_rdy) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_IEXEC:   state_d = S_IWB;
            S_MEMWB,
            S_ALUWB,
            S_IWB,
            S_BRANCH,
            S_JUMP,
            S_JAL,
            S_TRAP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        iord       = 1'b0;
        immsrc     = 1'b0;
        memtoreg   = c_MEMTOREG_ALU;
        regdst     = c_REGDST_RT;
        alusrcb    = c_ALUSRCB_B;
        pcsrc      = c_PCSRC_ALU;
        aluop      = c_ALUOP_ADD;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = c_ALUSRCB_FOUR;
                irwrite = w_mem_rdy;
                pcwrite = w_mem_rdy;
            end
            S_DECODE: begin
                alusrcb = c_ALUSRCB_IMMSH;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = c_ALUSRCB_IMM;
            end
            S_MEMREAD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = c_MEMTOREG_DATA;
                regdst   = c_REGDST_RT;
            end
            S_MEMWRITE: begin
                // Strobe stays up for the whole wait so memory can accept late.
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                alusrcb = c_ALUSRCB_B;
                aluop   = c_ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = c_REGDST_RD;
                memtoreg = c_MEMTOREG_ALU;
            end
            S_BRANCH: begin
                alusrca   = 1'b1;
                alusrcb   = c_ALUSRCB_B;
                aluop     = c_ALUOP_SUB;
                pcsrc     = c_PCSRC_ALUOUT;
                branch    = w_is_beq;
                branch_ne = w_is_bne;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = c_ALUSRCB_IMM;
                if (w_is_andi) begin
                    aluop  = c_ALUOP_AND;
                    immsrc = 1'b1;
                end else if (w_is_ori) begin
                    aluop  = c_ALUOP_OR;
                    immsrc = 1'b1;
                end else if (w_is_slti) begin
                    aluop  = c_ALUOP_SLT;
                end else begin
                    aluop  = c_ALUOP_ADD;
                end
            end
            S_IWB: begin
                regwrite = 1'b1;
                regdst   = c_REGDST_RT;
                memtoreg = c_MEMTOREG_ALU;
            end
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = c_PCSRC_JUMP;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value.
                pcwrite  = 1'b1;
                pcsrc    = c_PCSRC_JUMP;
                regwrite = 1'b1;
                regdst   = c_REGDST_R31;
                memtoreg = c_MEMTOREG_PC;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_maindec_mc_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_maindec_mc_ext
// Description : Randomized instruction-level bench for maindec_mc_ext across
//               three parameter sets, against a per-instruction trace model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maindec_mc_ext;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       pcwrite;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       branch;
        logic       branch_ne;
        logic       iord;
        logic       immsrc;
        logic [1:0] memtoreg;
        logic [1:0] regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       illegal_op;
        logic [3:0] state;
    } ctl_t;

    localparam int NDUT = 3;
    // Instance 0: full featured; 1: base ISA, no handshake; 2: silent illegal.
    localparam logic [NDUT-1:0] P_EXT  = 3'b101;
    localparam logic [NDUT-1:0] P_HS   = 3'b101;
    localparam logic [NDUT-1:0] P_TRAP = 3'b011;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_IMM = 4;
    localparam int K_J = 5, K_JAL = 6, K_ILL = 7;

    logic                 clk = 1'b0;
    logic [NDUT-1:0]      rst_v;
    logic [NDUT-1:0]      mr_v;
    logic [NDUT-1:0][5:0] op_v;
    logic [NDUT-1:0][24:0] obs_v;

    int   n_total = 0;
    int   n_bad   = 0;
    ctl_t exp_q[$];
    bit   mr_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        logic       pcw, mwr, irw, rgw, asa, br, brn, iord, imm, ill;
        logic [1:0] m2r, rdst, asb, pcs;
        logic [2:0] aop;
        logic [3:0] st;
        maindec_mc_ext #(
            .EXT_ISA         (P_EXT[gi]),
            .MEM_HANDSHAKE   (P_HS[gi]),
            .TRAP_ON_ILLEGAL (P_TRAP[gi])
        ) u_dut (
            .clk        (clk),
            .reset      (rst_v[gi]),
            .op         (op_v[gi]),
            .mem_ready  (mr_v[gi]),
            .pcwrite    (pcw),
            .memwrite   (mwr),
            .irwrite    (irw),
            .regwrite   (rgw),
            .alusrca    (asa),
            .branch     (br),
            .branch_ne  (brn),
            .iord       (iord),
            .immsrc     (imm),
            .memtoreg   (m2r),
            .regdst     (rdst),
            .alusrcb    (asb),
            .pcsrc      (pcs),
            .aluop      (aop),
            .illegal_op (ill),
            .state_o    (st)
        );
        assign obs_v[gi] = {pcw, mwr, irw, rgw, asa, br, brn, iord, imm,
                            m2r, rdst, asb, pcs, aop, ill, st};
    end

    task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%07h exp=%07h (state got=%0d exp=%0d)",
                     tag, got, exp, got[3:0], exp[3:0]);
        end
    endtask

    function automatic ctl_t blank(input state_t s);
        ctl_t c;
        c       = '0;
        c.state = s;
        return c;
    endfunction

    function automatic int classify(input logic [5:0] op, input bit ext);
        case (op)
            6'd0:  return K_R;
            6'd35: return K_LW;
            6'd43: return K_SW;
            6'd4:  return K_BR;
            6'd8:  return K_IMM;
            6'd2:  return K_J;
            6'd5:  return ext ? K_BR : K_ILL;
            6'd12, 6'd13, 6'd10: return ext ? K_IMM : K_ILL;
            6'd3:  return ext ? K_JAL : K_ILL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic bit rnd();
        return bit'($urandom_range(1, 0));
    endfunction

    task automatic push(input ctl_t c, input bit m);
        exp_q.push_back(c);
        mr_q.push_back(m);
    endtask

    // Expected cycle-by-cycle trace of one instruction, from fetch back to fetch.
    task automatic build(input int k, input logic [5:0] op, input int fw, input int mw);
        bit   hs  = P_HS[k];
        bit   ext = P_EXT[k];
        bit   trp = P_TRAP[k];
        ctl_t c;
        exp_q.delete();
        mr_q.delete();
        if (hs) begin
            for (int i = 0; i < fw; i++) begin
                c = blank(S_FETCH); c.alusrcb = 2'b01; push(c, 1'b0);
            end
        end
        c = blank(S_FETCH); c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1;
        push(c, hs);
        c = blank(S_DECODE); c.alusrcb = 2'b11; push(c, rnd());
        case (classify(op, ext))
            K_R: begin
                c = blank(S_EXECUTE); c.alusrca = 1'b1; c.aluop = 3'b010; push(c, rnd());
                c = blank(S_ALUWB); c.regwrite = 1'b1; c.regdst = 2'b01; push(c, rnd());
            end
            K_LW, K_SW: begin
                c = blank(S_MEMADR); c.alusrca = 1'b1; c.alusrcb = 2'b10; push(c, rnd());
                if (op == 6'd35) c = blank(S_MEMREAD);
                else begin c = blank(S_MEMWRITE); c.memwrite = 1'b1; end
                c.iord = 1'b1;
                if (hs) for (int i = 0; i < mw; i++) push(c, 1'b0);
                push(c, hs);
                if (op == 6'd35) begin
                    c = blank(S_MEMWB); c.regwrite = 1'b1; c.memtoreg = 2'b01; push(c, rnd());
                end
            end
            K_BR: begin
                c = blank(S_BRANCH); c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01;
                c.branch = (op == 6'd4); c.branch_ne = (op == 6'd5); push(c, rnd());
            end
            K_IMM: begin
                c = blank(S_IEXEC); c.alusrca = 1'b1; c.alusrcb = 2'b10;
                case (op)
                    6'd12:   begin c.aluop = 3'b011; c.immsrc = 1'b1; end
                    6'd13:   begin c.aluop = 3'b100; c.immsrc = 1'b1; end
                    6'd10:   begin c.aluop = 3'b101; c.immsrc = 1'b0; end
                    default: begin c.aluop = 3'b000; c.immsrc = 1'b0; end
                endcase
                push(c, rnd());
                c = blank(S_IWB); c.regwrite = 1'b1; push(c, rnd());
            end
            K_J: begin
                c = blank(S_JUMP); c.pcwrite = 1'b1; c.pcsrc = 2'b10; push(c, rnd());
            end
            K_JAL: begin
                c = blank(S_JAL); c.pcwrite = 1'b1; c.pcsrc = 2'b10; c.regwrite = 1'b1;
                c.regdst = 2'b10; c.memtoreg = 2'b10; push(c, rnd());
            end
            default: begin
                if (trp) begin
                    c = blank(S_TRAP); c.illegal_op = 1'b1; push(c, rnd());
                end
            end
        endcase
    endtask

    task automatic step(input int k, input bit m, input bit r, input ctl_t e, input string tag);
        rst_v[k] = r;
        mr_v[k]  = m;
        #1;
        chk(tag, obs_v[k], e);
        @(posedge clk);
        #1;
    endtask

    // Idle instances are parked in reset so they stay in FETCH between runs.
    task automatic run(input int k, input logic [5:0] op, input int fw, input int mw);
        ctl_t e;
        bit   m;
        int   i = 0;
        op_v[k] = op;
        build(k, op, fw, mw);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = mr_q.pop_front();
            step(k, m, 1'b0, e, $sformatf("u%0d op=%02h c%0d", k, op, i));
            i++;
        end
        rst_v[k] = 1'b1;
        mr_v[k]  = 1'b0;
    endtask

    initial begin
        logic [5:0] pool [12];
        ctl_t       c;
        ctl_t       f_idle;
        pool  = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd10, 6'd2, 6'd3, 6'd63};
        rst_v = '1;
        mr_v  = '0;
        op_v  = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < NDUT; k++) begin
            c = blank(S_FETCH); c.alusrcb = 2'b01;
            c.irwrite = !P_HS[k]; c.pcwrite = !P_HS[k];
            chk($sformatf("reset u%0d", k), obs_v[k], c);
        end

        // Reset held two cycles in the middle of a MEMREAD wait.
        f_idle = blank(S_FETCH); f_idle.alusrcb = 2'b01;
        op_v[0] = 6'd35;
        c = f_idle; c.irwrite = 1'b1; c.pcwrite = 1'b1;
        step(0, 1'b1, 1'b0, c, "rstmid fetch");
        c = blank(S_DECODE); c.alusrcb = 2'b11;
        step(0, 1'b0, 1'b0, c, "rstmid decode");
        c = blank(S_MEMADR); c.alusrca = 1'b1; c.alusrcb = 2'b10;
        step(0, 1'b0, 1'b0, c, "rstmid memadr");
        c = blank(S_MEMREAD); c.iord = 1'b1;
        step(0, 1'b0, 1'b0, c, "rstmid memread");
        step(0, 1'b0, 1'b1, c, "rstmid memread_rst");
        step(0, 1'b0, 1'b1, f_idle, "rstmid fetch_rst1");
        step(0, 1'b0, 1'b0, f_idle, "rstmid fetch_rst2");
        step(0, 1'b0, 1'b0, f_idle, "rstmid fetch_wait");
        c = f_idle; c.irwrite = 1'b1; c.pcwrite = 1'b1;
        rst_v[0] = 1'b0; mr_v[0] = 1'b1; #1;
        chk("rstmid fetch_rdy", obs_v[0], c);
        rst_v[0] = 1'b1; mr_v[0] = 1'b0;
        @(posedge clk); #1;

        run(0, 6'd35, 3, 2);
        run(0, 6'd43, 0, 2);
        run(0, 6'd13, 1, 0);
        run(1, 6'd13, 0, 0);
        run(0, 6'd5, 0, 0);
        run(0, 6'd3, 0, 0);
        run(2, 6'd63, 0, 0);
        run(1, 6'd35, 2, 2);
        run(1, 6'd43, 1, 1);

        for (int n = 0; n < 200; n++) begin
            int         k;
            logic [5:0] op;
            k  = int'($urandom_range(NDUT - 1, 0));
            op = ($urandom_range(3, 0) == 0) ? 6'($urandom_range(63, 0))
                                             : pool[$urandom_range(11, 0)];
            run(k, op, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
